// File: rtl/rr_encoder_8_3.sv
// Round-robin 8-to-3 encoder: registered grant index and one-hot vector,
// held until acked, search start rotates past the last winner.
module rr_encoder_8_3 #(
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [(1<<IDX_W)-1:0] req,
    input  logic                  ack,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [(1<<IDX_W)-1:0] grant_onehot
);

    localparam int NUM_REQ = 1 << IDX_W;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    logic               state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] onehot_q, onehot_d;

    logic               release_grant;
    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;

    assign release_grant = (state_q == GRANT) && ack;

    // An acked grant moves the start just past the winner before searching
    assign search_start = release_grant ? idx_q + 1'b1 : ptr_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = search_start + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = GRANT;
                    idx_d    = win_idx;
                    onehot_d = win_onehot;
                end
            end
            GRANT: begin
                if (ack) begin
                    ptr_d = search_start;
                    if (win_found) begin
                        idx_d    = win_idx;
                        onehot_d = win_onehot;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign grant_valid  = (state_q == GRANT);
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;

endmodule
